// File: rtl/pwm_meter.sv
// Square/PWM input meter: reports period and high time (clk cycles) per accepted cycle.
// Optional glitch filter between synchronizer and edge detect: define PWM_METER_FILT_EN.
module pwm_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             stalled,
  output logic [7:0]       meas_cnt
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("pwm_meter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   lvl;
  logic                   lvl_d_q;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_METER_FILT_EN
  localparam int FCNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic              filt_q;
  logic [FCNT_W-1:0] fcnt_q;

  // Level flips on the FILT_LEN-th consecutive disagreeing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (s != filt_q) begin
      if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
        filt_q <= s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_d_q <= 1'b0;
    end else begin
      lvl_d_q <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d_q;
  assign fall = ~lvl & lvl_d_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;
  logic [7:0]       mcnt_q, mcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
      mcnt_q   <= mcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;
    mcnt_d   = mcnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == CNT_MAX) begin
          stall_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall) begin
            hi_d    = cnt_q;
            state_d = LOW;
          end
        end
      end
      LOW: begin
        // A rise in the same cycle as saturation still closes the period.
        if (rise) begin
          if (cnt_q >= CNT_MIN) begin
            period_d = cnt_q;
            high_d   = hi_q;
            valid_d  = 1'b1;
            mcnt_d   = mcnt_q + 8'd1;
            stall_d  = 1'b0;
          end
          cnt_d   = CNT_ONE;
          state_d = HIGH;
        end else if (cnt_q == CNT_MAX) begin
          stall_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign stalled    = stall_q;
  assign meas_cnt   = mcnt_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter (CNT_W=8); expectations adapt when PWM_METER_FILT_EN is defined.
module tb_pwm_meter;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MINP  = 4;
  localparam int FL    = 3;
`ifdef PWM_METER_FILT_EN
  localparam int LAT      = SYNC + 1 + FL;
  localparam int G_N      = 0;
  localparam int RUN_H    = 3;
  localparam int RUN_L    = 3;
  localparam int T6_P1    = 30;
  localparam int T6_H1    = 20;
  localparam int T6_NSTR  = 1;
`else
  localparam int LAT      = SYNC + 1;
  localparam int G_N      = 3;
  localparam int RUN_H    = 2;
  localparam int RUN_L    = 2;
  localparam int T6_P1    = 11;
  localparam int T6_H1    = 9;
  localparam int T6_NSTR  = 2;
`endif

  typedef struct {
    int per;
    int hi;
    int mc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             stalled;
  logic [7:0]       meas_cnt;

  int   n_total = 0;
  int   n_pass  = 0;
  int   prev_vld = 0;
  exp_t exp_q[$];

  pwm_meter #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MIN_PERIOD(MINP), .FILT_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period_out(period_out), .high_out(high_out),
    .meas_valid(meas_valid), .stalled(stalled), .meas_cnt(meas_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input int per, input int hi, input int mc);
    exp_t e;
    e.per = per;
    e.hi  = hi;
    e.mc  = mc;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period_out), 0);
    check({tag, "_high"}, int'(high_out), 0);
    check({tag, "_valid"}, int'(meas_valid), 0);
    check({tag, "_stalled"}, int'(stalled), 0);
    check({tag, "_cnt"}, int'(meas_cnt), 0);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (meas_valid) begin
      exp_t e;
      check("valid_back_to_back", prev_vld, 0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: period %0d high %0d cnt %0d, none expected",
                 period_out, high_out, meas_cnt);
      end else begin
        e = exp_q.pop_front();
        check("strobe_period", int'(period_out), e.per);
        check("strobe_high", int'(high_out), e.hi);
        check("strobe_cnt", int'(meas_cnt), e.mc);
      end
    end
    prev_vld = int'(meas_valid);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // 3 high / 5 low, four times: three closed periods
    drive(1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push(8, 3, i);
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    drive(1'b0, 20);
    check("t1_meas_cnt", int'(meas_cnt), 3);
    check("t1_period", int'(period_out), 8);
    check("t1_high", int'(high_out), 3);
    check("t1_stalled", int'(stalled), 0);

    // latency from sig_in rise to strobe
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 5);
    push(8, 3, 1);
    sig_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!meas_valid && n < 20);
    check("t2_latency", n, LAT);
    drive(1'b1, 3);
    drive(1'b0, 20);

    // glitch periods below MIN_PERIOD, then period 10
    do_reset();
    drive(1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b1, 5);
    drive(1'b0, 5);
    check("t3_cnt_after_glitch", int'(meas_cnt), 0);
    push(10, 5, 1);
    drive(1'b1, 5);
    drive(1'b0, 5);
    push(10, 5, 2);
    drive(1'b1, 5);
    drive(1'b0, 20);
    check("t3_meas_cnt", int'(meas_cnt), 2);

    // stall from constant high, recovery, then stall from constant low
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 300);
    check("t4_stall_high", int'(stalled), 1);
    check("t4_cnt_no_meas", int'(meas_cnt), 0);
    drive(1'b0, 6);
    drive(1'b1, 6);
    check("t4_stall_held", int'(stalled), 1);
    drive(1'b0, 6);
    push(12, 6, 1);
    drive(1'b1, 6);
    check("t4_stall_cleared", int'(stalled), 0);
    drive(1'b0, 6);
    push(12, 6, 2);
    drive(1'b1, 3);
    drive(1'b0, 300);
    check("t4_stall_low", int'(stalled), 1);
    check("t4_meas_cnt", int'(meas_cnt), 2);

    // reset while in HIGH
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 5);
    push(8, 3, 1);
    drive(1'b1, 8);
    rst    = 1'b1;
    sig_in = 1'b0;
    @(posedge clk);
    #1;
    check_zero("t5_mid_reset");
    rst = 1'b0;
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 5);
    push(8, 3, 1);
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("t5_meas_cnt", int'(meas_cnt), 1);

    // 2-cycle low glitch inside a 20-cycle high
    do_reset();
    drive(1'b0, 4);
    drive(1'b1, 9);
    if (T6_NSTR == 2) push(T6_P1, T6_H1, 1);
    drive(1'b0, 2);
    drive(1'b1, 9);
    drive(1'b0, 10);
    if (T6_NSTR == 2) push(19, 9, 2);
    else push(T6_P1, T6_H1, 1);
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("t6_meas_cnt", int'(meas_cnt), T6_NSTR);

    // MIN_PERIOD boundary and meas_cnt wrap 255 -> 0
    do_reset();
    drive(1'b0, 4);
    for (int i = 0; i < G_N; i++) begin
      drive(1'b1, 2);
      drive(1'b0, 1);
    end
    for (int i = 0; i < 257; i++) begin
      if (i > 0) push(RUN_H + RUN_L, RUN_H, i % 256);
      drive(1'b1, RUN_H);
      drive(1'b0, RUN_L);
    end
    drive(1'b0, 20);
    check("t7_cnt_wrapped", int'(meas_cnt), 0);
    check("t7_period", int'(period_out), RUN_H + RUN_L);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
